// File: rtl/multiword_add_seq.sv
// Word-serial N*M-bit adder built around a single N-bit carry-lookahead slice.
// Optional macro SUBTRACT_EN adds a sub port that turns the operation into A-B.

module multiword_add_cla #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    logic         carry_i;
    logic         prop;

    // Each carry is the flattened generate/propagate sum, not a ripple chain.
    always_comb begin
        // NOTE: every always_comb variable gets a default first so no path can infer a latch.
        g       = a & b;
        p       = a ^ b;
        c       = '0;
        carry_i = 1'b0;
        prop    = 1'b0;
        c[0]    = ci;
        for (int i = 0; i < N; i++) begin
            carry_i = g[i];
            prop    = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry_i = carry_i | (g[j] & prop);
                prop    = prop & p[j];
            end
            c[i+1] = carry_i | (ci & prop);
        end
    end

    assign s  = p ^ c[N-1:0];
    assign co = c[N];

endmodule

module multiword_add_seq #(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N*M-1:0] op_a,
    input  logic [N*M-1:0] op_b,
    input  logic         cin,
`ifdef SUBTRACT_EN
    input  logic         sub,
`endif
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N*M-1:0] res_sum,
    output logic         res_cout,
    output logic         busy
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam logic [IW-1:0] LAST = IW'(M - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [IW-1:0]  idx;
    logic           carry_q;
    logic [N*M-1:0] sum_q;
    logic [N*M-1:0] a_q;
    logic [N*M-1:0] b_q;
    logic           sub_q;
    logic           sub_in;

    logic [N-1:0]   add_a;
    logic [N-1:0]   add_b;
    logic [N-1:0]   add_sum;
    logic           add_cout;

`ifdef SUBTRACT_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    // Subtraction is A + ~B + 1; the +1 comes from the carry register preload.
    assign add_a = a_q[idx*N +: N];
    assign add_b = b_q[idx*N +: N] ^ {N{sub_q}};

    multiword_add_cla #(.N(N)) u_cla (
        .a  (add_a),
        .b  (add_b),
        .ci (carry_q),
        .s  (add_sum),
        .co (add_cout)
    );

    // NOTE: operand registers carry no reset; every accept reloads them before they are read.
    always_ff @(posedge clk) begin
        if (start_ready && start_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            sub_q <= sub_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            res_valid   <= 1'b0;
            busy        <= 1'b0;
            start_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        state       <= RUN;
                        idx         <= '0;
                        carry_q     <= sub_in ? 1'b1 : cin;
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[idx*N +: N] <= add_sum;
                    carry_q           <= add_cout;
                    if (idx == LAST) begin
                        state     <= DONE;
                        idx       <= '0;
                        res_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state       <= IDLE;
                        res_valid   <= 1'b0;
                        busy        <= 1'b0;
                        start_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    idx         <= '0;
                    res_valid   <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                end
            endcase
        end
    end

    assign res_sum  = sum_q;
    assign res_cout = carry_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (N=8, M=4): vector table, corner
// sequences, and a back-to-back random run against an arithmetic model.

module tb_multiword_add_seq;

    localparam int N = 8;
    localparam int M = 4;
    localparam int W = N * M;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         busy;

    int checks = 0;
    int errors = 0;

    multiword_add_seq #(.N(N), .M(M)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
`ifdef SUBTRACT_EN
        .sub         (sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t         vecs[$];
    logic [W:0]   exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full-width arithmetic reference: {cout, sum}.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic sb);
        if (sb)
            return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else
            return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    endfunction

    // Accepts one operation, scrambles the inputs, and counts cycles to res_valid.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic sb, output int lat);
        int w;
        w = 0;
        while (!start_ready && w < 20) begin
            tick;
            w++;
        end
        check("ready_before_accept", start_ready, 1);
        op_a = a;
        op_b = b;
        cin = ci;
        sub = sb;
        start_valid = 1'b1;
        tick;
        start_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        cin = 1'($urandom);
        sub = 1'($urandom);
        lat = 0;
        while (!res_valid && lat < 20) begin
            tick;
            lat++;
        end
    endtask

    task automatic handshake;
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        check("idle_after_handshake_valid", res_valid, 0);
        check("idle_after_handshake_ready", start_ready, 1);
        check("idle_after_handshake_busy", busy, 0);
    endtask

    initial begin
        int lat;
        int seen;
        int cyc;
        int accepted;
        int last_acc;
        bit acc;
        logic [W:0] exp;

        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0});
        vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1});
        vecs.push_back('{32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b0, 32'h0100_0100, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0});
`ifdef SUBTRACT_EN
        vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1});
`endif

        // Reset state.
        rst_n = 1'b0;
        tick;
        tick;
        check("reset_res_valid", res_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_start_ready", start_ready, 1);
        check("reset_res_sum", res_sum, 0);
        check("reset_res_cout", res_cout, 0);
        rst_n = 1'b1;
        tick;

        // Vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, lat);
            check($sformatf("vec%0d_latency", i), lat, M);
            check($sformatf("vec%0d_sum", i), res_sum, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), res_cout, vecs[i].cout);
            check($sformatf("vec%0d_busy", i), busy, 1);
            handshake;
        end

        // Held result with stalled consumer and ignored start pulses.
        run_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, lat);
        check("hold_latency", lat, M);
        for (int k = 0; k < 5; k++) begin
            start_valid = (k % 2 == 0);
            op_a = $urandom;
            tick;
            check("hold_valid", res_valid, 1);
            check("hold_sum", res_sum, 32'h2143_6588);
            check("hold_cout", res_cout, 0);
            check("hold_no_accept", start_ready, 0);
        end
        start_valid = 1'b0;
        handshake;

        // Reset during the second RUN cycle aborts the operation.
        op_a = 32'hDEAD_BEEF;
        op_b = 32'h0102_0304;
        start_valid = 1'b1;
        tick;
        start_valid = 1'b0;
        tick;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_ready", start_ready, 1);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (res_valid) seen++;
            tick;
        end
        check("abort_no_valid", seen, 0);
        run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, lat);
        check("after_abort_latency", lat, M);
        check("after_abort_sum", res_sum, 32'h0000_0002);
        check("after_abort_cout", res_cout, 0);
        handshake;

        // Back-to-back random traffic.
        accepted = 0;
        last_acc = -1;
        cyc = 0;
        op_a = $urandom;
        op_b = $urandom;
        cin = 1'($urandom);
`ifdef SUBTRACT_EN
        sub = 1'($urandom);
`else
        sub = 1'b0;
`endif
        start_valid = 1'b1;
        res_ready = 1'b1;
        while ((accepted < 1000 || exp_q.size() != 0) && cyc < 7000) begin
            acc = start_valid && start_ready;
            if (acc) begin
                exp_q.push_back(ref_add(op_a, op_b, cin, sub));
                if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, M + 2);
                last_acc = cyc;
                accepted++;
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_unexpected_result: got %h expected none", {res_cout, res_sum});
                end else begin
                    exp = exp_q.pop_front();
                    check("b2b_sum", res_sum, exp[W-1:0]);
                    check("b2b_cout", res_cout, exp[W]);
                end
            end
            tick;
            cyc++;
            if (acc) begin
                op_a = $urandom;
                op_b = $urandom;
                cin = 1'($urandom);
`ifdef SUBTRACT_EN
                sub = 1'($urandom);
`endif
                if (accepted == 1000) start_valid = 1'b0;
            end
        end
        check("b2b_accepted", accepted, 1000);
        check("b2b_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 Parameter N, default 8, width in bits of the single internal lookahead adder slice.
REQ-002 Parameter M, default 4, number of N-bit words per operand; legal range M >= 1.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 start_valid  input  1  requester presents an operation.
REQ-006 start_ready  output  1  block accepts an operation this cycle.
REQ-007 op_a  input  N*M  first operand; word k is bits [k*N +: N].
REQ-008 op_b  input  N*M  second operand.
REQ-009 cin  input  1  carry-in of the full-width add.
REQ-010 sub  input  1  subtract select; present only when SUBTRACT_EN is defined.
REQ-011 res_valid  output  1  result is available.
REQ-012 res_ready  input  1  consumer takes the result.
REQ-013 res_sum  output  N*M  full-width result.
REQ-014 res_cout  output  1  carry-out of the most significant word.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 The block SHALL contain exactly one N-bit carry-lookahead adder instance and compute the N*M-bit sum word-serially, least significant word first.
REQ-017 FSM states SHALL be IDLE, RUN, and DONE.
REQ-018 IDLE: start_ready=1; on start_valid=1, latch op_a, op_b, cin, and sub, clear the word index to 0, load the carry register, and go to RUN.
REQ-019 start_ready SHALL be 1 only in IDLE; start_valid in RUN or DONE is ignored and causes no latching.
REQ-020 RUN: each cycle, add latched word[idx] of A and B with the carry register, write the N-bit sum into res_sum word idx, load the carry register with the adder carry-out, and increment idx.
REQ-021 RUN -> DONE on the cycle in which idx==M-1 is processed; res_valid SHALL therefore rise exactly M cycles after the accepting edge.
REQ-022 DONE: res_valid=1, res_sum holds the full result, and res_cout = final carry register; both stay stable until the handshake completes.
REQ-023 DONE with res_ready=1 SHALL return to IDLE on the next edge; a new operation can be accepted no earlier than the following cycle (throughput M+2 cycles).
REQ-024 DONE with res_ready=0 SHALL hold indefinitely without corrupting outputs.
REQ-025 Input changes after acceptance SHALL NOT affect the in-flight operation.
REQ-026 M=1 SHALL be a single-cycle RUN; res_sum and res_cout SHALL be identical to a direct N-bit add.
REQ-027 The word index counter SHALL be ceil(log2(M)) bits wide (minimum 1) and SHALL never exceed M-1.
REQ-028 res_sum words not yet written in RUN are don't-care; only DONE values are specified.

Reset
REQ-029 With rst_n=0 at a rising edge: state=IDLE, idx=0, carry register=0, res_sum=0, res_cout=0, res_valid=0, busy=0, start_ready=1 from the next cycle.
REQ-030 Reset asserted in RUN or DONE SHALL abort the operation; no res_valid pulse for it is ever produced.

Configuration
REQ-031 Macro SUBTRACT_EN: when defined, the sub port exists; with latched sub=1 each B word is bitwise inverted before the adder, and the carry register loads 1 at accept, ignoring cin, so the result is A-B with res_cout=1 meaning no borrow.
REQ-032 Without SUBTRACT_EN, the sub port is absent, the block only adds, and the carry register loads cin at accept.

Verification (N=8, M=4)
REQ-033 Accept A=0xFFFFFFFF, B=0x00000001, cin=0 -> 4 cycles later res_valid=1, res_sum=0x00000000, res_cout=1.
REQ-034 Accept A=0x12345678, B=0x0F0F0F0F, cin=1, res_ready=0 for 5 cycles -> res_sum=0x21436588, res_cout=0, held stable; start_valid pulses during busy are ignored.
REQ-035 SUBTRACT_EN build: A=0x00000005, B=0x00000007, sub=1 -> res_sum=0xFFFFFFFE, res_cout=0; A=7, B=5 -> res_sum=0x00000002, res_cout=1.
REQ-036 rst_n=0 for 1 cycle at the 2nd RUN cycle -> state IDLE, res_valid never rises for that operation; the next operation A=1, B=1 -> res_sum=0x00000002.
REQ-037 Back-to-back with start_valid and res_ready held at 1 -> accepts spaced exactly 6 cycles; 1000 random operands match the reference sum and carry.
